// File: rtl/gemm_tile_sched.sv
// gemm_tile_sched: tile-loop sequencer for the systolic GEMM core, driving weight/ifmap reads,
// PE-array strobes and the delayed activation write port.
module gemm_tile_sched #(
    parameter int PE_SIZE         = 14,
    parameter int ROW_TILES       = 21,
    parameter int COL_TILES       = 5,
    parameter int DRAIN_CYC       = 28,
    parameter int MEM0_ADDR_WIDTH = 13,
    parameter int MEM1_ADDR_WIDTH = 11,
    parameter int MEM2_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       mem0_ce0_o,
    output logic [MEM0_ADDR_WIDTH-1:0] mem0_addr0_o,
    output logic                       mem1_ce0_o,
    output logic [MEM1_ADDR_WIDTH-1:0] mem1_addr0_o,
    output logic                       w_load_o,
    output logic                       x_valid_o,
    output logic                       acc_clr_o,
    output logic                       acc_rd_o,
    output logic [$clog2(PE_SIZE)-1:0] acc_idx_o,
    output logic                       mem2_ce0_o,
    output logic                       mem2_we0_o,
    output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr0_o
);
    localparam int KW = $clog2(PE_SIZE);
    localparam int RW = $clog2(ROW_TILES + 1);
    localparam int CW = $clog2(COL_TILES + 1);
    localparam int DW = $clog2(DRAIN_CYC + 1);

    if (COL_TILES * ROW_TILES * PE_SIZE > (64'd1 << MEM1_ADDR_WIDTH) ||
        ROW_TILES * PE_SIZE > (64'd1 << MEM0_ADDR_WIDTH) ||
        COL_TILES * PE_SIZE > (64'd1 << MEM2_ADDR_WIDTH) || DRAIN_CYC < 1) begin : g_bad_param
        $error("gemm_tile_sched: address range exceeds BRAM width or DRAIN_CYC < 1");
    end

    typedef enum logic [2:0] {IDLE, LOAD_W, FEED, DRAIN, WRITE, DONE} state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              c_q, c_d;
    logic [RW-1:0]              r_q, r_d;
    logic [KW-1:0]              k_q, k_d;
    logic [DW-1:0]              d_q, d_d;
    logic                       k_last;
    logic [MEM0_ADDR_WIDTH-1:0] a0_d;
    logic [MEM1_ADDR_WIDTH-1:0] a1_d;
    logic [MEM2_ADDR_WIDTH-1:0] a2_d, wr_addr_q;

    assign k_last = k_q == KW'(PE_SIZE - 1);
    assign a0_d   = MEM0_ADDR_WIDTH'(32'(r_d) * PE_SIZE + 32'(k_d));
    assign a1_d   = MEM1_ADDR_WIDTH'((32'(c_d) * ROW_TILES + 32'(r_d)) * PE_SIZE + 32'(k_d));
    assign a2_d   = MEM2_ADDR_WIDTH'(32'(c_d) * PE_SIZE + 32'(k_d));

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        r_d     = r_q;
        k_d     = k_q;
        d_d     = d_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = LOAD_W;
                c_d     = '0;
                r_d     = '0;
                k_d     = '0;
            end
            LOAD_W: begin
                k_d     = k_last ? '0 : k_q + 1'b1;
                state_d = k_last ? FEED : LOAD_W;
            end
            FEED: begin
                k_d     = k_last ? '0 : k_q + 1'b1;
                d_d     = '0;
                state_d = k_last ? DRAIN : FEED;
            end
            DRAIN: if (d_q == DW'(DRAIN_CYC - 1)) begin
                state_d = (r_q == RW'(ROW_TILES - 1)) ? WRITE : LOAD_W;
                r_d     = (r_q == RW'(ROW_TILES - 1)) ? r_q : r_q + 1'b1;
            end else begin
                d_d = d_q + 1'b1;
            end
            WRITE: begin
                k_d = k_last ? '0 : k_q + 1'b1;
                if (k_last) begin
                    state_d = (c_q == CW'(COL_TILES - 1)) ? DONE : LOAD_W;
                    c_d     = (c_q == CW'(COL_TILES - 1)) ? c_q : c_q + 1'b1;
                    r_d     = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            c_q          <= '0;
            r_q          <= '0;
            k_q          <= '0;
            d_q          <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            mem0_ce0_o   <= 1'b0;
            mem0_addr0_o <= '0;
            mem1_ce0_o   <= 1'b0;
            mem1_addr0_o <= '0;
            w_load_o     <= 1'b0;
            x_valid_o    <= 1'b0;
            acc_clr_o    <= 1'b0;
            acc_rd_o     <= 1'b0;
            acc_idx_o    <= '0;
            wr_addr_q    <= '0;
            mem2_ce0_o   <= 1'b0;
            mem2_we0_o   <= 1'b0;
            mem2_addr0_o <= '0;
        end else begin
            state_q      <= state_d;
            c_q          <= c_d;
            r_q          <= r_d;
            k_q          <= k_d;
            d_q          <= d_d;
            busy_o       <= state_d != IDLE;
            done_o       <= state_d == DONE;
            mem1_ce0_o   <= state_d == LOAD_W;
            mem1_addr0_o <= (state_d == LOAD_W) ? a1_d : '0;
            acc_clr_o    <= state_d == LOAD_W && r_d == '0 && k_d == '0;
            mem0_ce0_o   <= state_d == FEED;
            mem0_addr0_o <= (state_d == FEED) ? a0_d : '0;
            acc_rd_o     <= state_d == WRITE;
            acc_idx_o    <= (state_d == WRITE) ? k_d : '0;
            wr_addr_q    <= (state_d == WRITE) ? a2_d : '0;
            w_load_o     <= mem1_ce0_o;
            x_valid_o    <= mem0_ce0_o;
            mem2_ce0_o   <= acc_rd_o;
            mem2_we0_o   <= acc_rd_o;
            mem2_addr0_o <= wr_addr_q;
        end
    end
endmodule

// File: tb/tb_gemm_tile_sched.sv
// tb_gemm_tile_sched: directed bench with address scoreboards and a read-back BRAM model
// for the tile sequencer, plus a minimal-parameter instance for the single-pass edge case.
module tb_gemm_tile_sched;
    localparam int PE   = 4;
    localparam int RT   = 3;
    localparam int CT   = 2;
    localparam int DR   = 8;
    localparam int COL  = RT * (2 * PE + DR) + PE;
    localparam int LAST = CT * COL + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        busy, done, m0ce, m1ce, wl, xv, clr, ard, m2ce, m2we;
    logic [12:0] m0a;
    logic [10:0] m1a;
    logic [1:0]  aidx;
    logic [9:0]  m2a;

    logic        start2 = 1'b0;
    logic        busy2, done2, m0ce2, m1ce2, wl2, xv2, clr2, ard2, m2ce2, m2we2;
    logic [12:0] m0a2;
    logic [10:0] m1a2;
    logic [1:0]  aidx2;
    logic [9:0]  m2a2;

    always #5 clk = ~clk;

    gemm_tile_sched #(.PE_SIZE(PE), .ROW_TILES(RT), .COL_TILES(CT), .DRAIN_CYC(DR)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy), .done_o(done),
        .mem0_ce0_o(m0ce), .mem0_addr0_o(m0a), .mem1_ce0_o(m1ce), .mem1_addr0_o(m1a),
        .w_load_o(wl), .x_valid_o(xv), .acc_clr_o(clr), .acc_rd_o(ard), .acc_idx_o(aidx),
        .mem2_ce0_o(m2ce), .mem2_we0_o(m2we), .mem2_addr0_o(m2a)
    );

    gemm_tile_sched #(.PE_SIZE(4), .ROW_TILES(1), .COL_TILES(1), .DRAIN_CYC(1)) dut2 (
        .clk(clk), .rst(rst), .start_i(start2), .busy_o(busy2), .done_o(done2),
        .mem0_ce0_o(m0ce2), .mem0_addr0_o(m0a2), .mem1_ce0_o(m1ce2), .mem1_addr0_o(m1a2),
        .w_load_o(wl2), .x_valid_o(xv2), .acc_clr_o(clr2), .acc_rd_o(ard2), .acc_idx_o(aidx2),
        .mem2_ce0_o(m2ce2), .mem2_we0_o(m2we2), .mem2_addr0_o(m2a2)
    );

    // BRAM models return the registered address as read data
    logic [10:0] m1_q = '0;
    logic [12:0] m0_q = '0;
    always @(posedge clk) begin
        if (m1ce) m1_q <= m1a;
        if (m0ce) m0_q <= m0a;
    end

    int total = 0;
    int bad = 0;
    int rel = 0;
    int base = 0;
    logic run_on = 1'b0;
    logic p1_ce = 1'b0, p0_ce = 1'b0;
    logic [10:0] p1_a = '0;
    logic [12:0] p0_a = '0;
    int q1[$], q0[$], q2[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm();
        for (int c = 0; c < CT; c++) begin
            for (int r = 0; r < RT; r++) for (int k = 0; k < PE; k++) q1.push_back((c * RT + r) * PE + k);
            for (int r = 0; r < RT; r++) for (int k = 0; k < PE; k++) q0.push_back(r * PE + k);
            for (int k = 0; k < PE; k++) q2.push_back(c * PE + k);
        end
        base = rel;
        run_on = 1'b1;
    endtask

    task automatic check1();
        int o, ws, idx_e;
        logic clr_e, rd_e, we_e;
        o = rel - base;
        clr_e = 1'b0; rd_e = 1'b0; we_e = 1'b0; idx_e = 0;
        for (int c = 0; c < CT; c++) begin
            ws = 1 + c * COL + RT * (2 * PE + DR);
            if (run_on && o == 1 + c * COL) clr_e = 1'b1;
            if (run_on && o >= ws && o < ws + PE) begin rd_e = 1'b1; idx_e = o - ws; end
            if (run_on && o > ws && o <= ws + PE) we_e = 1'b1;
        end
        chk("busy", busy, run_on && o >= 1 && o <= LAST);
        chk("done", done, run_on && o == LAST);
        chk("acc_clr", clr, clr_e);
        chk("acc_rd", ard, rd_e);
        if (rd_e) chk("acc_idx", aidx, idx_e);
        chk("mem2_we", m2we, we_e);
        chk("mem2_ce", m2ce, we_e);
        if (q1.size() == 0) chk("m1_extra", m1ce, 0);
        else if (m1ce) chk("m1_addr", m1a, q1.pop_front());
        if (q0.size() == 0) chk("m0_extra", m0ce, 0);
        else if (m0ce) chk("m0_addr", m0a, q0.pop_front());
        if (q2.size() == 0) chk("m2_extra", m2we, 0);
        else if (m2we) chk("m2_addr", m2a, q2.pop_front());
        chk("w_load", wl, p1_ce);
        if (wl && p1_ce) chk("w_data", m1_q, p1_a);
        chk("x_valid", xv, p0_ce);
        if (xv && p0_ce) chk("x_data", m0_q, p0_a);
        p1_ce = m1ce; p1_a = m1a; p0_ce = m0ce; p0_a = m0a;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        rel++;
        check1();
    endtask

    task automatic queues_empty(input string tag);
        chk({tag, "_m1_left"}, q1.size(), 0);
        chk({tag, "_m0_left"}, q0.size(), 0);
        chk({tag, "_m2_left"}, q2.size(), 0);
    endtask

    initial begin
        int done_at, n1, n0, n2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {busy, done, m0ce, m0a, m1ce, m1a, wl, xv, clr, ard, aidx, m2ce, m2we, m2a}, 0);
        chk("rst_outputs2", {busy2, done2, m0ce2, m1ce2, wl2, xv2, clr2, ard2, m2ce2, m2we2}, 0);
        rst = 1'b0;
        // single run
        arm();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        while (rel < 106) step();
        queues_empty("run1");
        // start in first IDLE cycle accepted; starts at +10 and in DONE ignored
        arm();
        while (rel - base < 106) begin
            start_i = (rel - base == 0) || (rel - base == 10) || (rel - base == 105);
            step();
        end
        start_i = 1'b0;
        queues_empty("run2");
        repeat (3) step();
        // reset mid-run
        arm();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        while (rel - base < 60) step();
        rst = 1'b1;
        run_on = 1'b0;
        q1.delete(); q0.delete(); q2.delete();
        p1_ce = 1'b0; p0_ce = 1'b0;
        step();
        chk("midrst_all", {busy, done, m0ce, m0a, m1ce, m1a, wl, xv, clr, ard, aidx, m2ce, m2we, m2a}, 0);
        rst = 1'b0;
        repeat (5) step();
        arm();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        while (rel - base < 106) step();
        queues_empty("run3");
        // single-pass parameter edge
        done_at = -1; n1 = 0; n0 = 0; n2 = 0;
        start2 = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            start2 = 1'b0;
            if (done2 && done_at < 0) done_at = i;
            if (m1ce2) begin chk("e_m1_addr", m1a2, n1); n1++; end
            if (m0ce2) begin chk("e_m0_addr", m0a2, n0); n0++; end
            if (m2we2) begin chk("e_m2_addr", m2a2, n2); n2++; end
        end
        chk("e_done_cycle", done_at, 14);
        chk("e_m1_count", n1, 4);
        chk("e_m0_count", n0, 4);
        chk("e_m2_count", n2, 4);
        chk("e_busy_end", busy2, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gemm_tile_sched.md
# gemm_tile_sched

Tile-loop sequencer for the systolic GEMM core. On a start pulse it walks every (column-tile, row-tile) pair: it preloads a PE_SIZE×PE_SIZE weight tile from the weight BRAM, streams the matching ifmap slice from the ifmap BRAM, and waits out the array skew. After the last row tile of each column it drains the accumulators into the activation-map BRAM. It sits between the gemm start control and the three true dual-port BRAMs, driving port 0 of each plus the PE-array load/valid/accumulator strobes.

## Interface
- PE_SIZE, 14, systolic array edge; words per tile phase
- ROW_TILES, 21, row tiles per column (padded weight rows / PE_SIZE)
- COL_TILES, 5, column tiles (padded weight cols / PE_SIZE)
- DRAIN_CYC, 28, idle cycles after each FEED for skew flush (≥1)
- MEM0_ADDR_WIDTH, 13, ifmap BRAM address width
- MEM1_ADDR_WIDTH, 11, weight BRAM address width
- MEM2_ADDR_WIDTH, 10, activation BRAM address width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle start request; honoured only in IDLE
- busy_o  out  1  high whenever state ≠ IDLE
- done_o  out  1  one-cycle pulse in DONE
- mem0_ce0_o / mem0_addr0_o  out  1 / MEM0_ADDR_WIDTH  ifmap read enable/address
- mem1_ce0_o / mem1_addr0_o  out  1 / MEM1_ADDR_WIDTH  weight read enable/address
- w_load_o  out  1  weight word on mem1 q0 valid; shift into array
- x_valid_o  out  1  ifmap word on mem0 q0 valid; inject into array
- acc_clr_o  out  1  clear PE accumulators (one pulse per column tile)
- acc_rd_o / acc_idx_o  out  1 / $clog2(PE_SIZE)  accumulator row read strobe/index
- mem2_ce0_o / mem2_we0_o / mem2_addr0_o  out  1 / 1 / MEM2_ADDR_WIDTH  activation write port; data comes from the array

## Operation
- States: IDLE, LOAD_W, FEED, DRAIN, WRITE, DONE. Counters: c (column tile), r (row tile), k (word in phase, 0..PE_SIZE-1), d (drain).
- IDLE: start_i=1 → LOAD_W with c=r=k=0. start_i ignored in every other state.
- LOAD_W: mem1_ce0_o=1, mem1_addr0_o=(c·ROW_TILES+r)·PE_SIZE+k; PE_SIZE cycles → FEED. acc_clr_o=1 in the first LOAD_W cycle when r=0.
- FEED: mem0_ce0_o=1, mem0_addr0_o=r·PE_SIZE+k; PE_SIZE cycles → DRAIN.
- DRAIN: DRAIN_CYC cycles, no memory access. Then if r<ROW_TILES-1: r++ → LOAD_W. Else → WRITE.
- WRITE: acc_rd_o=1, acc_idx_o=k; PE_SIZE cycles. Then if c<COL_TILES-1: c++, r=0 → LOAD_W. Else → DONE.
- DONE: done_o=1 for one cycle → IDLE.
- The mem2 port is a 1-cycle delayed copy of the WRITE strobe: mem2_ce0_o=mem2_we0_o=1, mem2_addr0_o=c·PE_SIZE+k registered from the acc_rd_o cycle. The last write of a column lands in the first cycle of the following LOAD_W or DONE.
- All addresses are computed from counters, with no wrap. The maximum values are COL_TILES·ROW_TILES·PE_SIZE-1 for mem1, ROW_TILES·PE_SIZE-1 for mem0 and COL_TILES·PE_SIZE-1 for mem2, and each must fit its width (static parameter check).

## Timing
- Reset: state=IDLE, all counters 0. Every output is 0 the cycle after rst is sampled high. rst mid-run aborts immediately, with no pending delayed write or strobe emitted afterwards.
- BRAM read latency is 1 cycle: w_load_o = mem1_ce0_o delayed 1 cycle; x_valid_o = mem0_ce0_o delayed 1 cycle.
- start_i sampled at cycle 0 → LOAD_W and busy_o=1 at cycle 1.
- Per column tile: ROW_TILES·(2·PE_SIZE+DRAIN_CYC)+PE_SIZE cycles. DONE follows directly; busy_o falls the cycle after DONE.
- done_o coincides with the final mem2_we0_o. A start_i in the DONE cycle is ignored; a start_i in the first IDLE cycle is accepted.

## Test plan
Bench parameters: PE_SIZE=4, ROW_TILES=3, COL_TILES=2, DRAIN_CYC=8.
- Single run: start_i at cycle 0 → busy_o high cycles 1–105, done_o only at cycle 105, exactly 24 mem1 reads (addr 0..23 in order), 24 mem0 reads (0..11 twice), 8 mem2 writes (addr 0..7).
- Alignment: the BRAM model returns its address as data → every w_load_o/x_valid_o cycle sees data equal to the address issued one cycle earlier. acc_clr_o pulses at cycles 1 and 53 only.
- Ignored start: start_i pulsed at cycles 10 and 105 → trace identical to the single run. start_i at cycle 106 → second run, done_o at cycle 211.
- Reset mid-run: rst high at cycle 60 → from cycle 61 all outputs are 0 and busy_o=0, with no mem2 write afterwards. A new start then produces the full single-run trace.
- Write phase: in cycles 49–52 acc_idx_o=0..3. mem2_we0_o is high in cycles 50–53 with addr 0..3, and the cycle-53 write overlaps acc_clr_o/LOAD_W.
- Parameter edge DRAIN_CYC=1, ROW_TILES=1, COL_TILES=1: one LOAD_W/FEED/DRAIN/WRITE pass; done_o at cycle 1+4+4+1+4=14.
